// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage
//   Instruction-fetch front end for the RISCVCPU decode stage. Keeps the fetch PC,
//   issues word reads on a valid/ready request channel under a credit limit, collects
//   in-order responses in a small prefetch FIFO, and hands {pc, instr} to decode.
//   A redirect from execute flushes the FIFO and marks every in-flight response stale.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  prefetch entries (power of two, >= 2); also caps outstanding requests
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel (word aligned byte address)
//   imem_rsp_valid/data              in-order instruction responses
//   if_valid/ready, if_instr, if_pc  FIFO head toward decode
//   redirect_valid, redirect_pc      taken branch/jump restart
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   perf_fetched  count of instructions handed to decode
//   perf_stall    cycles with decode ready but nothing to hand over
`default_nettype none

module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic credit_ok;
  logic req_fire;
  logic rsp_ok;
  logic rsp_drop;
  logic push;
  logic pop;

  // Low address bits of a redirect target are architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit covers both buffered entries and responses still owed by memory.
  assign credit_ok      = (count_q + outst_q) < DEPTH_C;
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok   = imem_rsp_valid && (outst_q != '0);
  assign rsp_drop = rsp_ok && (drop_q != '0);
  assign push     = rsp_ok && (drop_q == '0) && !redirect_valid;
  assign pop      = (count_q != '0) && if_ready && !redirect_valid;

  // Decode side is driven purely from FIFO registers.
  assign if_valid = (count_q != '0);
  assign if_pc    = pc_mem_q[rd_ptr_q];
  assign if_instr = instr_mem_q[rd_ptr_q];

  // Next-state for PC, FIFO pointers and credit/drop bookkeeping.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    outst_d  = outst_q + CW'(req_fire) - CW'(rsp_ok);

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rsp_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // Everything still owed after this cycle is stale; outstanding already
      // includes responses marked stale by any earlier redirect.
      drop_d   = outst_q - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1'b1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State and FIFO storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[AW'(i)]    <= RESET_PC;
        instr_mem_q[AW'(i)] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Free-running counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (if_ready && !if_valid) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  // Memory must never answer a request that was not issued.
  a_rsp_has_owner : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outst_q != '0))
    else $error("riscv_fetch_stage: imem_rsp_valid with no outstanding request");

endmodule

`default_nettype wire
